// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/memory/write-back control unit.
// It owns pc, ir and the retired-instruction count, and handshakes with memory through mem_req/mem_ready.
module cpu_sequencer (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_run,
    input  logic [31:0] i_instr,
    input  logic        i_mem_ready,
    output logic [7:0]  o_pc,
    output logic [31:0] o_ir,
    output logic [3:0]  o_reg_dest,
    output logic        o_reg_we,
    output logic        o_wb_sel,
    output logic        o_mem_req,
    output logic [1:0]  o_rw,
    output logic        o_addr_sel,
    output logic        o_halted,
    output logic [7:0]  o_retired
);
    localparam logic [3:0] OP_LDR  = 4'hA;
    localparam logic [3:0] OP_STR  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t      r_state, w_next;
    logic [7:0]  r_pc, r_retired;
    logic [31:0] r_ir;
    logic        w_ldr, w_str, w_retire;

    assign w_ldr = r_ir[27:24] == OP_LDR;
    assign w_str = r_ir[27:24] == OP_STR;

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            S_IDLE:   w_next = i_run ? S_FETCH : S_IDLE;
            S_FETCH:  w_next = i_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: w_next = (r_ir[27:24] == OP_HALT) ? S_HALT : (w_ldr || w_str) ? S_MEM : S_EXEC;
            S_EXEC:   w_next = S_WB;
            S_MEM: begin
                w_retire = i_mem_ready && w_str;
                w_next   = !i_mem_ready ? S_MEM : !w_str ? S_WB : i_run ? S_FETCH : S_IDLE;
            end
            S_WB: begin
                w_retire = 1'b1;
                w_next   = i_run ? S_FETCH : S_IDLE;
            end
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_pc      <= 8'd0;
            r_ir      <= 32'd0;
            r_retired <= 8'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && i_mem_ready)
                r_ir <= i_instr;
            if (w_retire) begin
                r_pc      <= r_pc + 8'd1;
                r_retired <= r_retired + 8'd1;
            end
        end
    end

    // Moore outputs: everything decodes from the registered state and latched opcode
    assign o_pc       = r_pc;
    assign o_ir       = r_ir;
    assign o_retired  = r_retired;
    assign o_reg_dest = r_ir[22:19];
    assign o_reg_we   = r_state == S_WB;
    assign o_wb_sel   = (r_state == S_WB) && w_ldr;
    assign o_mem_req  = (r_state == S_FETCH) || (r_state == S_MEM);
    assign o_addr_sel = r_state == S_MEM;
    assign o_halted   = r_state == S_HALT;
    assign o_rw       = (r_state == S_FETCH) ? 2'b01 : (r_state == S_MEM) ? (w_str ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: memory responder plus instruction-level scoreboard for cpu_sequencer.
// Expected per-instruction effects are queued at issue time and checked when the DUT retires.
module tb_cpu_sequencer;
    logic        clk = 1'b0;
    logic        i_reset, i_run, i_mem_ready;
    logic [31:0] i_instr;
    logic [7:0]  o_pc, o_retired;
    logic [31:0] o_ir;
    logic [3:0]  o_reg_dest;
    logic        o_reg_we, o_wb_sel, o_mem_req, o_addr_sel, o_halted;
    logic [1:0]  o_rw;

    cpu_sequencer dut (
        .i_clk(clk), .i_reset(i_reset), .i_run(i_run), .i_instr(i_instr), .i_mem_ready(i_mem_ready),
        .o_pc(o_pc), .o_ir(o_ir), .o_reg_dest(o_reg_dest), .o_reg_we(o_reg_we), .o_wb_sel(o_wb_sel),
        .o_mem_req(o_mem_req), .o_rw(o_rw), .o_addr_sel(o_addr_sel), .o_halted(o_halted),
        .o_retired(o_retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          waits;
        logic [31:0] w;
        bit          fetch;
    } req_t;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] ret;
        int         we;
        logic [3:0] dest;
        int         wb;
        int         rw;
        int         mem_cyc;
        int         cyc;
    } exp_t;

    req_t req_q[$];
    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    logic [7:0] m_pc, m_ret;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] mk(logic [3:0] op, logic [3:0] d);
        logic [31:0] w;
        w = $urandom;
        w[27:24] = op;
        w[22:19] = d;
        return w;
    endfunction

    // Instruction-level reference: cycle count and side effects follow from the opcode class and wait counts
    task automatic add(logic [31:0] w, int fw, int mw);
        exp_t e;
        req_t r;
        logic [3:0] op;
        op = w[27:24];
        r.waits = fw; r.w = w; r.fetch = 1'b1;
        req_q.push_back(r);
        if (op == 4'hF) return;
        e.pc = m_pc;
        m_pc = m_pc + 8'd1;
        m_ret = m_ret + 8'd1;
        e.ret = m_ret;
        e.dest = w[22:19];
        e.we = (op == 4'hB) ? 0 : 1;
        e.wb = (op == 4'hA) ? 1 : 0;
        e.rw = (op == 4'hB) ? 2 : (op == 4'hA) ? 1 : 0;
        if (op == 4'hA || op == 4'hB) begin
            r.waits = mw; r.w = $urandom; r.fetch = 1'b0;
            req_q.push_back(r);
            e.mem_cyc = mw + 1;
            e.cyc = fw + mw + ((op == 4'hB) ? 3 : 4);
        end else begin
            e.mem_cyc = 0;
            e.cyc = fw + 4;
        end
        exp_q.push_back(e);
    endtask

    // Memory responder: serves requests in program order with the queued wait counts
    int cnt = 0;
    always @(posedge clk) begin
        #2;
        if (i_reset) begin
            req_q.delete();
            cnt = 0;
            i_mem_ready = 1'b1;
            i_instr = $urandom;
        end else if (o_mem_req && req_q.size() > 0) begin
            if (cnt == 0) chk("req_kind", {31'd0, o_addr_sel}, {31'd0, !req_q[0].fetch});
            i_mem_ready = (cnt == req_q[0].waits);
            i_instr = i_mem_ready ? req_q[0].w : $urandom;
            if (i_mem_ready) begin
                void'(req_q.pop_front());
                cnt = 0;
            end else cnt++;
        end else begin
            i_mem_ready = o_mem_req ? 1'b0 : 1'($urandom_range(0, 1));
            i_instr = $urandom;
        end
    end

    // Scoreboard monitor: accumulates one instruction's observed behaviour, compares at retire
    bit         started;
    logic [7:0] prev_ret, a_pc;
    int         a_cyc, a_we, a_we_at, a_wb, a_mem, a_rw;
    logic [3:0] a_dest;
    bit         a_rw_bad;
    exp_t       e;

    task automatic clr();
        a_cyc = 0; a_we = 0; a_we_at = 0; a_wb = 0; a_mem = 0; a_rw = 0; a_dest = 0; a_rw_bad = 0; a_pc = 0;
    endtask

    always @(negedge clk) begin
        if (i_reset) begin
            started = 0;
            prev_ret = 8'd0;
            exp_q.delete();
            clr();
        end else begin
            if (o_retired != prev_ret) begin
                prev_ret = o_retired;
                if (exp_q.size() == 0) chk("unexpected_retire", {24'd0, o_retired}, 32'hFFFF_FFFF);
                else begin
                    e = exp_q.pop_front();
                    chk("retired", {24'd0, o_retired}, {24'd0, e.ret});
                    chk("pc_after", {24'd0, o_pc}, {24'd0, e.pc + 8'd1});
                    chk("pc_during", {24'd0, a_pc}, {24'd0, e.pc});
                    chk("cycles", a_cyc, e.cyc);
                    chk("we_count", a_we, e.we);
                    chk("mem_cycles", a_mem, e.mem_cyc);
                    chk("mem_rw", a_rw, e.rw);
                    chk("rw_stable", {31'd0, a_rw_bad}, 0);
                    if (e.we != 0) begin
                        chk("we_last_cycle", a_we_at, e.cyc);
                        chk("reg_dest", {28'd0, a_dest}, {28'd0, e.dest});
                        chk("wb_sel", a_wb, e.wb);
                    end
                end
                clr();
            end
            if (o_mem_req) started = 1;
            if (started && !o_halted) begin
                if (a_cyc == 0) a_pc = o_pc;
                a_cyc++;
                if (o_reg_we) begin
                    a_we++; a_we_at = a_cyc; a_dest = o_reg_dest; a_wb = int'(o_wb_sel);
                end
                if (o_mem_req && !o_addr_sel && o_rw != 2'b01) a_rw_bad = 1;
                if (o_mem_req && o_addr_sel) begin
                    a_mem++;
                    if (a_mem == 1) a_rw = int'(o_rw);
                    else if (int'(o_rw) != a_rw) a_rw_bad = 1;
                end
            end
        end
    end

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(int limit);
        int n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            cyc1();
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic wait_halt(logic [7:0] pc_exp);
        int n = 0;
        while (!o_halted && n < 5000) begin
            cyc1();
            n++;
        end
        chk("halt_reached", {31'd0, o_halted}, 1);
        chk("halt_pc", {24'd0, o_pc}, {24'd0, pc_exp});
    endtask

    task automatic rand_op(output logic [3:0] op);
        int v;
        v = $urandom_range(0, 12);
        op = 4'(v >= 10 ? v + 2 : v);
    endtask

    initial begin
        logic [3:0] op;
        int n;
        i_reset = 1'b1;
        i_run = 1'b1;
        repeat (2) cyc1();
        chk("rst_pc", {24'd0, o_pc}, 0);
        chk("rst_ir", o_ir, 0);
        chk("rst_dest", {28'd0, o_reg_dest}, 0);
        chk("rst_we", {31'd0, o_reg_we}, 0);
        chk("rst_wb", {31'd0, o_wb_sel}, 0);
        chk("rst_req", {31'd0, o_mem_req}, 0);
        chk("rst_rw", {30'd0, o_rw}, 0);
        chk("rst_asel", {31'd0, o_addr_sel}, 0);
        chk("rst_halt", {31'd0, o_halted}, 0);
        chk("rst_ret", {24'd0, o_retired}, 0);
        i_reset = 1'b0;
        m_pc = 0; m_ret = 0;
        add(32'h0118_0000, 0, 0);
        add(mk(4'hA, 4'd5), 0, 2);
        add(mk(4'hB, 4'd9), 0, 0);
        for (int i = 0; i < 4; i++) begin
            rand_op(op);
            add(mk(op, 4'($urandom)), $urandom_range(0, 1), 0);
        end
        add(mk(4'hF, 4'd0), 0, 0);
        cyc1();
        chk("first_fetch_req", {31'd0, o_mem_req}, 1);
        chk("first_fetch_asel", {31'd0, o_addr_sel}, 0);
        drain(200);
        wait_halt(8'd7);
        for (int i = 0; i < 20; i++) begin
            cyc1();
            chk("halt_hold_pc", {24'd0, o_pc}, 7);
            chk("halt_hold_req", {31'd0, o_mem_req}, 0);
            chk("halt_hold_flag", {31'd0, o_halted}, 1);
        end
        i_reset = 1'b1;
        cyc1();
        i_reset = 1'b0;
        chk("halt_rst_pc", {24'd0, o_pc}, 0);
        chk("halt_rst_flag", {31'd0, o_halted}, 0);

        m_pc = 0; m_ret = 0;
        for (int i = 0; i < 300; i++) begin
            n = $urandom_range(0, 3);
            if (n == 0) op = 4'hA;
            else if (n == 1) op = 4'hB;
            else rand_op(op);
            add(mk(op, 4'($urandom)), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end
        add(mk(4'hF, 4'd0), 0, 0);
        drain(5000);
        wait_halt(8'd44);
        chk("wrap_retired", {24'd0, o_retired}, 44);

        i_reset = 1'b1;
        repeat (2) cyc1();
        i_reset = 1'b0;
        m_pc = 0; m_ret = 0;
        add(mk(4'hA, 4'd2), 0, 50);
        n = 0;
        while (!(o_mem_req && o_addr_sel) && n < 50) begin
            cyc1();
            n++;
        end
        chk("abort_in_mem", {31'd0, o_addr_sel}, 1);
        cyc1();
        i_reset = 1'b1;
        cyc1();
        chk("abort_req", {31'd0, o_mem_req}, 0);
        chk("abort_rw", {30'd0, o_rw}, 0);
        chk("abort_ret", {24'd0, o_retired}, 0);
        chk("abort_pc", {24'd0, o_pc}, 0);
        i_reset = 1'b0;
        m_pc = 0; m_ret = 0;
        add(mk(4'h3, 4'd6), 0, 0);
        n = 0;
        while (!o_mem_req && n < 20) begin
            cyc1();
            n++;
        end
        i_run = 1'b0;
        drain(50);
        for (int i = 0; i < 10; i++) begin
            cyc1();
            chk("stop_req", {31'd0, o_mem_req}, 0);
            chk("stop_pc", {24'd0, o_pc}, 1);
            chk("stop_ret", {24'd0, o_retired}, 1);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end
endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control unit for the single-issue 32-bit processor datapath: RAM, register bank, source muxes, ALU and memory control. It owns the program counter, latches the fetched instruction and runs each instruction through a fetch/decode/execute/memory/write-back state machine. It drives the register-bank write strobe and destination, the memory read/write code and the address-bus select, and waits on a memory-ready handshake. It replaces the free-running instruction counter, so that LDR/STR and memory wait states are sequenced correctly.

## Interface
- OP_LDR, 4'hA, opcode (instr[27:24]) of load-register
- OP_STR, 4'hB, opcode of store-register
- OP_HALT, 4'hF, opcode that stops execution; every other opcode is an ALU op
- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- run  in  1  enable execution; sampled in IDLE and at instruction retire
- instr  in  32  instruction word from RAM (valid when mem_ready during FETCH)
- mem_ready  in  1  memory access complete; sampled only while mem_req=1
- pc  out  8  address of current instruction
- ir  out  32  latched instruction; fields: [27:24] opcode, [22:19] dest, [18:15] src1, [14:11] src2
- reg_dest  out  4  equals ir[22:19]
- reg_we  out  1  register-bank write strobe, one cycle per writing instruction
- wb_sel  out  1  write-back source: 0 = ALU result, 1 = memory data
- mem_req  out  1  memory access request
- rw  out  2  00 idle, 01 read, 10 write
- addr_sel  out  1  address bus source: 0 = pc, 1 = data address (src operand)
- halted  out  1  high in HALT state
- retired  out  8  count of retired instructions, wraps 255→0

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Outputs decode from the registered state (Moore). pc, ir and retired are registers.
- IDLE: all strobes 0. If run=1, go to FETCH.
- FETCH: mem_req=1, rw=01, addr_sel=0. If mem_ready=1: ir<=instr, go to DECODE. Otherwise stay.
- DECODE: one cycle, strobes 0.
  - opcode=OP_HALT: go to HALT.
  - OP_LDR or OP_STR: go to MEM.
  - Otherwise: go to EXEC.
- EXEC: one cycle for ALU settle, then go to WB.
- MEM: mem_req=1, addr_sel=1, rw=01 for LDR and 10 for STR. Hold until mem_ready=1.
  - LDR: go to WB.
  - STR: retire.
- WB: reg_we=1, wb_sel=1 for LDR and 0 for ALU ops. Retire.
- Retire (WB exit or STR MEM completion): pc<=pc+1 (8-bit wrap 255→0) and retired<=retired+1. Then go to FETCH if run=1, else IDLE.
- HALT: halted=1, all strobes 0, pc frozen. Only reset exits; run is ignored.
- run deasserted mid-instruction: the instruction completes; the stop takes effect at retire.

## Timing
- Reset values: state IDLE, pc=0, ir=0, reg_dest=0, reg_we=0, wb_sel=0, mem_req=0, rw=00, addr_sel=0, halted=0, retired=0.
- Reset asserted in any state, including mid-MEM with mem_req=1: mem_req and rw read 0 from the next edge. No retire and no pc update occur.
- Zero-wait memory (mem_ready=1 on first request cycle):
  - ALU op = 4 cycles (FETCH, DECODE, EXEC, WB).
  - LDR = 4 cycles (FETCH, DECODE, MEM, WB).
  - STR = 3 cycles.
- Each cycle of mem_ready=0 while mem_req=1 adds exactly one cycle.
- mem_ready while mem_req=0 has no effect.
- reg_we is high for exactly one cycle per ALU/LDR instruction and never for STR or HALT.
- The pc increment and the reg_we pulse take effect on the same edge: the WB exit edge.
- rw never changes during a request (mem_req stays high until the mem_ready edge). rw=10 appears only in MEM for STR.

## Test plan
- Reset: hold reset 2 cycles with run=1 and mem_ready=1 → all outputs at reset values. First FETCH occurs in the cycle after reset drops.
- ALU op 32'h01180000 (opcode 1, dest 3), mem_ready=1, run=1:
  - reg_we=1 with reg_dest=3 and wb_sel=0 in cycle 4 only.
  - pc 0→1 and retired=1 after cycle 4.
- LDR (opcode A, dest 5) with mem_ready low for 2 MEM cycles:
  - MEM lasts 3 cycles with rw=01 and addr_sel=1.
  - Then WB with wb_sel=1 and reg_we for one cycle; total 6 cycles.
- STR (opcode B), zero wait → rw=10 for one cycle in cycle 3, no reg_we, pc+1 after cycle 3.
- HALT at pc=7 → halted=1 two cycles after fetch. pc stays 7 and mem_req stays 0 for 20 cycles with run=1. A reset pulse returns to IDLE with pc=0.
- Wrap and abort:
  - 256 back-to-back ALU ops → pc and retired wrap 255→0.
  - reset asserted during a stalled MEM → mem_req=0 next cycle, retired unchanged until the next retire.
